// File: rtl/rfid_uid_poller_if.sv
// Byte-level link between the UID poller and the 8-bit SPI master.
// The poller drives start/tx; the SPI master returns busy/rx.
interface rfid_uid_poller_if;
  logic       spi_start_n;
  logic [7:0] spi_tx;
  logic       spi_busy;
  logic [7:0] spi_rx;

  modport master (
    output spi_start_n,
    output spi_tx,
    input  spi_busy,
    input  spi_rx
  );

  modport slave (
    input  spi_start_n,
    input  spi_tx,
    output spi_busy,
    output spi_rx
  );
endinterface

// File: rtl/rfid_uid_poller.sv
// Periodic RFID UID poller: sends a UID request, shifts in 4 UID bytes, checks them
// against two authorised tags, then reports the alarm state to the Arduino bridge.
module rfid_uid_poller #(
  parameter int unsigned POLL_DIV   = 500000,
  parameter logic [7:0]  CMD_UID    = 8'hAA,
  parameter logic [7:0]  STATE_BASE = 8'hBA,
  parameter logic [31:0] AUTH_UID0  = 32'h332C1EB7,
  parameter logic [31:0] AUTH_UID1  = 32'h336BF410,
  parameter int unsigned BUSY_TMO   = 2000000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               sys_state,
  rfid_uid_poller_if.master        spi,
  output logic [31:0]              uid,
  output logic                     uid_valid,
  output logic                     auth_pulse,
  output logic                     poll_active,
  output logic                     timeout_err
);

  localparam int unsigned PW = $clog2(POLL_DIV + 2);
  localparam int unsigned TW = $clog2(BUSY_TMO + 2);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_DIV);
  localparam logic [TW-1:0] TMO_LAST    = TW'(BUSY_TMO - 1);
  localparam logic [2:0]    IDX_LAST    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    tx_q, tx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   uid_q, uid_d;

  logic          start_n;
  logic          valid_pulse;
  logic          auth_hit;
  logic          tmo_pulse;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      poll_cnt_q <= POLL_RELOAD;
      tmo_q      <= '0;
      tx_q       <= '0;
      shadow_q   <= '0;
      uid_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      tmo_q      <= tmo_d;
      tx_q       <= tx_d;
      shadow_q   <= shadow_d;
      uid_q      <= uid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    poll_cnt_d  = poll_cnt_q;
    tmo_d       = tmo_q;
    tx_d        = tx_q;
    shadow_d    = shadow_q;
    uid_d       = uid_q;
    start_n     = 1'b1;
    valid_pulse = 1'b0;
    auth_hit    = 1'b0;
    tmo_pulse   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (poll_cnt_q != '0) begin
          poll_cnt_d = poll_cnt_q - 1'b1;
        end else if (enable) begin
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        unique case (idx_q)
          3'd0:     tx_d = CMD_UID;
          IDX_LAST: tx_d = STATE_BASE + 8'(sys_state);
          default:  tx_d = 8'h00;
        endcase
        state_d = ST_START;
      end

      ST_START: begin
        start_n = 1'b0;
        tmo_d   = '0;
        state_d = ST_WAIT_HI;
      end

      // Abort fires in the BUSY_TMO-th cycle spent waiting in either state.
      ST_WAIT_HI: begin
        if (spi.spi_busy) begin
          tmo_d   = '0;
          state_d = ST_WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          tmo_pulse  = 1'b1;
          poll_cnt_d = POLL_RELOAD;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_WAIT_LO: begin
        if (!spi.spi_busy) begin
          state_d = ST_CAPTURE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_pulse  = 1'b1;
          poll_cnt_d = POLL_RELOAD;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      // uid is loaded on the way into DONE so it is already new while uid_valid is high.
      ST_CAPTURE: begin
        unique case (idx_q)
          3'd1:    shadow_d[31:24] = spi.spi_rx;
          3'd2:    shadow_d[23:16] = spi.spi_rx;
          3'd3:    shadow_d[15:8]  = spi.spi_rx;
          3'd4:    shadow_d[7:0]   = spi.spi_rx;
          default: ;
        endcase
        if (idx_q == IDX_LAST) begin
          uid_d   = shadow_q;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_LOAD;
        end
      end

      ST_DONE: begin
        valid_pulse = 1'b1;
        auth_hit    = (uid_q != '0) && (uid_q != '1) &&
                      ((uid_q == AUTH_UID0) || (uid_q == AUTH_UID1));
        poll_cnt_d  = POLL_RELOAD;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign spi.spi_start_n = start_n;
  assign spi.spi_tx      = tx_q;
  assign uid             = uid_q;
  assign uid_valid       = valid_pulse;
  assign auth_pulse      = auth_hit;
  assign poll_active     = (state_q != ST_IDLE);
  assign timeout_err     = tmo_pulse;

endmodule

// File: tb/tb_rfid_uid_poller.sv
// Bench for rfid_uid_poller: scripted SPI slave model, uid scoreboard, vector table
// and hand-written sequences for timeout, reset, enable and busy-timing corners.
module tb_rfid_uid_poller;
  localparam int unsigned POLL_DIV = 20;
  localparam int unsigned BUSY_TMO = 50;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  sys_state;
  logic [31:0] uid;
  logic        uid_valid, auth_pulse, poll_active, timeout_err;

  rfid_uid_poller_if spi ();

  rfid_uid_poller #(
    .POLL_DIV (POLL_DIV),
    .BUSY_TMO (BUSY_TMO)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .enable      (enable),
    .sys_state   (sys_state),
    .spi         (spi),
    .uid         (uid),
    .uid_valid   (uid_valid),
    .auth_pulse  (auth_pulse),
    .poll_active (poll_active),
    .timeout_err (timeout_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] uid;
    logic        auth;
  } exp_t;

  typedef struct {
    logic [47:0] rx;
    logic [1:0]  st;
    logic [31:0] uid;
    logic        auth;
    logic [7:0]  last_tx;
  } vec_t;

  exp_t       sb_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  exp_t       mon_e;
  vec_t       vecs[6];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_valid = 0;
  int n_tmo = 0;
  int start_cyc = 0;
  int fall_cyc = 0;
  int tmo_cyc = 0;
  int mode = 0;   // 0 normal, 1 busy never rises, 2 busy already high at START

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // SPI slave: driven on the falling edge so the DUT sees stable inputs.
  initial begin : spi_model
    int phase;
    int cnt;
    logic [7:0] cur;
    logic [7:0] tx_seen;
    phase = 0;
    cnt = 0;
    cur = '0;
    tx_seen = '0;
    spi.spi_busy = 1'b0;
    spi.spi_rx = '0;
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        phase = 0;
        spi.spi_busy = (mode == 2);
      end else begin
        case (phase)
          0: begin
            spi.spi_busy = (mode == 2);
            if (!spi.spi_start_n) begin
              n_starts++;
              start_cyc = cyc;
              tx_seen = spi.spi_tx;
              if (tx_q.size() > 0) chk("tx_byte", 32'(tx_seen), 32'(tx_q.pop_front()));
              cur = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
              if (mode == 0) begin cnt = 10; phase = 1; end
              else if (mode == 2) begin cnt = 2; phase = 2; end
            end
          end
          1: begin
            cnt--;
            if (cnt == 0) begin
              spi.spi_busy = 1'b1;
              cnt = 3;
              phase = 2;
            end
          end
          default: begin
            cnt--;
            if (cnt == 0) begin
              spi.spi_busy = 1'b0;
              spi.spi_rx = cur;
              fall_cyc = cyc;
              chk("tx_hold", 32'(spi.spi_tx), 32'(tx_seen));
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (reset) begin
      if (uid_valid) begin
        n_valid++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_uid_valid: got pulse with uid %h, want none", uid);
        end else begin
          mon_e = sb_q.pop_front();
          chk("uid", uid, mon_e.uid);
          chk("auth_pulse", 32'(auth_pulse), 32'(mon_e.auth));
          chk("fall_to_valid", 32'(cyc - fall_cyc), 32'd2);
        end
      end else if (auth_pulse) begin
        n_cmp++;
        n_bad++;
        $display("FAIL auth_without_valid: got auth_pulse=1, want 0");
      end
      if (timeout_err) begin
        n_tmo++;
        tmo_cyc = cyc;
      end
    end
  end

  function automatic int probe(input int which);
    case (which)
      0:       return n_valid;
      1:       return n_starts;
      2:       return n_tmo;
      3:       return int'(poll_active);
      default: return int'(uid_valid);
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input string name);
    int k;
    k = 0;
    while (probe(which) < target && k < 3000) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (probe(which) < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out, got %0d want %0d", name, probe(which), target);
    end
  endtask

  task automatic push_frame(input vec_t v);
    exp_t e;
    for (int i = 5; i >= 0; i--) rx_q.push_back(v.rx[i*8 +: 8]);
    tx_q.push_back(8'hAA);
    for (int i = 0; i < 4; i++) tx_q.push_back(8'h00);
    tx_q.push_back(v.last_tx);
    e.uid = v.uid;
    e.auth = v.auth;
    sb_q.push_back(e);
  endtask

  // Enable is dropped as soon as the frame is underway; the frame must still complete.
  task automatic run_frame(input vec_t v);
    int tgt;
    push_frame(v);
    sys_state = v.st;
    tgt = n_valid + 1;
    enable = 1'b1;
    wait_for(3, 1, "poll_start");
    enable = 1'b0;
    wait_for(0, tgt, "frame_done");
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int idle;
    int act;
    int base;
    int tgt;

    vecs[0] = '{48'h5A_332C1EB7_C3, 2'd1, 32'h332C1EB7, 1'b1, 8'hBB};
    vecs[1] = '{48'h5A_12345678_C3, 2'd3, 32'h12345678, 1'b0, 8'hBD};
    vecs[2] = '{48'h5A_00000000_C3, 2'd0, 32'h00000000, 1'b0, 8'hBA};
    vecs[3] = '{48'hFF_FFFFFFFF_FF, 2'd2, 32'hFFFFFFFF, 1'b0, 8'hBC};
    vecs[4] = '{48'h00_336BF410_00, 2'd0, 32'h336BF410, 1'b1, 8'hBA};
    vecs[5] = '{48'h5A_336BF411_C3, 2'd3, 32'h336BF411, 1'b0, 8'hBD};

    reset = 1'b0;
    enable = 1'b0;
    sys_state = 2'd0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_start_n", 32'(spi.spi_start_n), 32'd1);
    chk("rst_spi_tx", 32'(spi.spi_tx), 32'd0);
    chk("rst_uid", uid, 32'd0);
    chk("rst_pulses", {29'd0, uid_valid, auth_pulse, timeout_err}, 32'd0);
    chk("rst_poll_active", 32'(poll_active), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // All-zero UID, then the idle gap before the next automatic frame.
    push_frame(vecs[2]);
    push_frame(vecs[4]);
    sys_state = 2'd0;
    tgt = n_valid + 2;
    enable = 1'b1;
    wait_for(4, 1, "zero_frame_valid");
    idle = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLOCK_50);
      if (poll_active) break;
      idle++;
    end
    chk("idle_after_done", 32'(idle), 32'(POLL_DIV + 1));
    enable = 1'b0;
    wait_for(0, tgt, "follow_frame_done");

    // Busy never rises: abort after BUSY_TMO cycles, uid untouched.
    mode = 1;
    tx_q.push_back(8'hAA);
    tgt = n_tmo + 1;
    enable = 1'b1;
    wait_for(3, 1, "tmo_poll_start");
    enable = 1'b0;
    wait_for(2, tgt, "timeout_pulse");
    chk("tmo_latency", 32'(tmo_cyc - start_cyc), 32'(BUSY_TMO));
    chk("uid_hold_after_tmo", uid, 32'h336BF410);
    rx_q.delete();
    mode = 0;

    // Busy already high at START must count as the rising edge.
    mode = 2;
    @(negedge CLOCK_50);
    run_frame(vecs[1]);
    mode = 0;

    // sys_state changes after the last byte is loaded: status byte must not move.
    push_frame(vecs[0]);
    sys_state = 2'd1;
    base = n_starts;
    tgt = n_valid + 1;
    enable = 1'b1;
    wait_for(3, 1, "st_poll_start");
    enable = 1'b0;
    wait_for(1, base + 6, "idx5_start");
    sys_state = 2'd2;
    wait_for(0, tgt, "st_frame_done");

    // Enable low in IDLE with the counter expired holds off polling.
    push_frame(vecs[4]);
    sys_state = 2'd0;
    base = n_starts;
    act = 0;
    repeat (100) begin
      @(negedge CLOCK_50);
      if (poll_active || !spi.spi_start_n) act++;
    end
    chk("idle_hold_cycles", 32'(act), 32'd0);
    chk("idle_hold_starts", 32'(n_starts - base), 32'd0);
    tgt = n_valid + 1;
    enable = 1'b1;
    @(negedge CLOCK_50);
    chk("load_after_enable", 32'(poll_active), 32'd1);
    enable = 1'b0;
    wait_for(0, tgt, "enable_frame_done");

    // Reset during byte 3, then restart after a full poll interval.
    push_frame(vecs[0]);
    sys_state = 2'd1;
    base = n_starts;
    tgt = n_valid;
    enable = 1'b1;
    wait_for(3, 1, "rst_poll_start");
    wait_for(1, base + 4, "idx3_start");
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("midrst_start_n", 32'(spi.spi_start_n), 32'd1);
    chk("midrst_uid", uid, 32'd0);
    chk("midrst_poll_active", 32'(poll_active), 32'd0);
    chk("midrst_spi_tx", 32'(spi.spi_tx), 32'd0);
    rx_q.delete();
    tx_q.delete();
    sb_q.delete();
    push_frame(vecs[1]);
    sys_state = 2'd3;
    #1 reset = 1'b1;
    idle = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLOCK_50);
      if (poll_active) break;
      idle++;
    end
    chk("idle_after_reset", 32'(idle), 32'(POLL_DIV + 1));
    enable = 1'b0;
    wait_for(0, tgt + 1, "restart_frame_done");

    repeat (5) @(negedge CLOCK_50);
    chk("timeout_count", 32'(n_tmo), 32'd1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
